// File: rtl/scale_shift_calib.sv
// Per-tile requantization shift calibrator: tracks the OR of sample magnitudes
// and derives the right-shift that keeps every sample within 16 signed bits.
// Optional build macro: SCALE_SHIFT_GUARD_EN (adds one guard bit, K = 14).
module scale_shift_calib (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [31:0] din,
   input  logic               din_valid,
   input  logic               din_last,
   output logic [3:0]         shift,
   output logic               shift_valid,
   output logic               sat,
   output logic [15:0]        count,
   output logic               busy
);

`ifdef SCALE_SHIFT_GUARD_EN
   localparam logic [5:0] K = 6'd14;
`else
   localparam logic [5:0] K = 6'd15;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [30:0] m_q;
   logic [15:0] cnt_q;
   logic [30:0] mag;
   logic        msb_nz;
   logic [4:0]  msb_p;
   logic [5:0]  raw;

   // sign-folded magnitude: leading sign copies become zeros
   assign mag = din[30:0] ^ {31{din[31]}};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = ACC;
         ACC:  if (din_valid && din_last) state_d = CALC;
         CALC: state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy        = (state_q != IDLE);
      shift_valid = (state_q == DONE);
   end

   // magnitude accumulator and sample counter
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q   <= '0;
         cnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         m_q   <= '0;
         cnt_q <= '0;
      end else if (state_q == ACC && din_valid) begin
         m_q   <= m_q | mag;
         cnt_q <= cnt_q + 16'd1;
      end
   end

   // highest set bit of the accumulated magnitude
   always_comb begin
      msb_nz = 1'b0;
      msb_p  = 5'd0;
      for (int i = 0; i < 31; i++) begin
         if (m_q[i]) begin
            msb_nz = 1'b1;
            msb_p  = i[4:0];
         end
      end
   end

   // raw shift = max(0, p + 1 - K)
   always_comb begin
      raw = 6'd0;
      if (msb_nz && {1'b0, msb_p} >= K)
         raw = {1'b0, msb_p} + 6'd1 - K;
   end

   // result registers, loaded on the CALC -> DONE edge only
   always_ff @(posedge clk) begin
      if (rst) begin
         shift <= 4'd0;
         sat   <= 1'b0;
         count <= 16'd0;
      end else if (state_q == CALC) begin
         shift <= (raw > 6'd15) ? 4'd15 : raw[3:0];
         sat   <= (raw > 6'd15);
         count <= cnt_q;
      end
   end

endmodule

// File: tb/tb_scale_shift_calib.sv
// Self-checking bench for scale_shift_calib: directed tiles plus random tiles
// checked against a model that searches for the smallest fitting shift.
module tb_scale_shift_calib;

`ifdef SCALE_SHIFT_GUARD_EN
   localparam int K = 14;
`else
   localparam int K = 15;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [31:0] din;
   logic               din_valid;
   logic               din_last;
   logic [3:0]         shift;
   logic               shift_valid;
   logic               sat;
   logic [15:0]        count;
   logic               busy;

   int checks = 0;
   int errors = 0;

   logic [3:0]  exp_shift = 4'd0;
   logic        exp_sat   = 1'b0;
   logic [15:0] exp_count = 16'd0;

   always #5 clk = ~clk;

   scale_shift_calib dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .din(din),
      .din_valid(din_valid),
      .din_last(din_last),
      .shift(shift),
      .shift_valid(shift_valid),
      .sat(sat),
      .count(count),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // smallest s such that every sample, arithmetically shifted by s,
   // lies in [-2^K, 2^K - 1]
   function automatic int ref_raw(input int s[$]);
      longint lo = -(longint'(1) << K);
      longint hi = (longint'(1) << K) - 1;
      for (int sh = 0; sh < 32; sh++) begin
         bit ok = 1'b1;
         foreach (s[i]) begin
            longint v = longint'(s[i]) >>> sh;
            if (v < lo || v > hi) ok = 1'b0;
         end
         if (ok) return sh;
      end
      return 32;
   endfunction

   task automatic run_tile(input string tag, input int s[$],
                           input bit gaps, input bit stray);
      int raw;
      raw = ref_raw(s);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_acc"}, 32'(busy), 32'd1);
      foreach (s[i]) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            din_valid = 1'b0;
            din_last  = 1'b0;
            din       = $urandom;
            @(negedge clk);
         end
         din       = s[i];
         din_valid = 1'b1;
         din_last  = (i == s.size() - 1);
         start     = stray;
         @(negedge clk);
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
      start     = 1'b0;
      check({tag, "_sv_calc"}, 32'(shift_valid), 32'd0);
      @(negedge clk);
      exp_shift = (raw > 15) ? 4'd15 : 4'(raw);
      exp_sat   = (raw > 15);
      exp_count = 16'(s.size());
      check({tag, "_sv_done"}, 32'(shift_valid), 32'd1);
      check({tag, "_shift"}, 32'(shift), 32'(exp_shift));
      check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
      check({tag, "_count"}, 32'(count), 32'(exp_count));
      @(negedge clk);
      check({tag, "_sv_after"}, 32'(shift_valid), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int q[$];
      int svs;
      rst       = 1'b1;
      start     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      din_last  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_shift", 32'(shift), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_sv", 32'(shift_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      run_tile("basic", '{100, -5, 32767}, 1'b0, 1'b0);
      run_tile("p32768", '{32768}, 1'b0, 1'b0);
      run_tile("n32769", '{-32769}, 1'b0, 1'b0);
      run_tile("n32768", '{-32768}, 1'b0, 1'b0);
      run_tile("big_m1", '{32'h3FFFFFFF, -1}, 1'b0, 1'b0);
      run_tile("sat_pos", '{32'h40000000}, 1'b0, 1'b0);
      run_tile("sat_min", '{32'sh80000000, 3}, 1'b1, 1'b0);
      run_tile("zeros", '{0, 0, 0, 0}, 1'b1, 1'b0);

      // reset in the middle of a tile
      run_tile("pre_rst", '{1 << 20}, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din       = 32'h0FFFFFFF;
         din_valid = 1'b1;
         din_last  = (i == 4);
         rst       = (i == 2);
         @(negedge clk);
         if (i == 2) begin
            rst       = 1'b0;
            din_valid = 1'b0;
            din_last  = 1'b0;
            break;
         end
      end
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_shift", 32'(shift), 32'd0);
      check("abort_count", 32'(count), 32'd0);
      svs = 0;
      for (int i = 0; i < 4; i++) begin
         svs += int'(shift_valid);
         @(negedge clk);
      end
      check("abort_no_sv", 32'(svs), 32'd0);
      run_tile("after_rst", '{70000, 70000}, 1'b0, 1'b0);

      // din_valid while idle must not leak into the next tile
      run_tile("hold_src", '{1 << 22, 5}, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         din       = 32'h7FFFFFFF;
         din_valid = 1'b1;
         din_last  = 1'b1;
         @(negedge clk);
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sv", 32'(shift_valid), 32'd0);
      check("hold_shift", 32'(shift), 32'(exp_shift));
      check("hold_count", 32'(count), 32'(exp_count));
      // start asserted throughout ACC, including with the last sample
      run_tile("stray_start", '{7, -9, 12}, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      check("stray_idle", 32'(busy), 32'd0);
      check("stray_hold", 32'(count), 32'(exp_count));

`ifdef SCALE_SHIFT_GUARD_EN
      run_tile("guard_16384", '{16384}, 1'b0, 1'b0);
      run_tile("guard_16383", '{16383}, 1'b0, 1'b0);
`endif

      // random tiles
      for (int t = 0; t < 25; t++) begin
         int n;
         q = {};
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++)
            q.push_back($signed($urandom) >>> $urandom_range(0, 31));
         run_tile("rand", q, 1'b1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
